// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, NB_DATA data bits LSB-first, SB_TICK-tick stop period.
// Timing comes from a 16x oversampling baud tick (i_s_tick); each bit lasts 16 ticks.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int unsigned NB_DATA     = 8,
    parameter int unsigned SB_TICK     = 16,
    parameter int unsigned NB_TICK_CNT = 5
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_s_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_tx_done_tick,
    output logic               o_busy
);

    localparam int unsigned NB_BIT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [NB_TICK_CNT-1:0] BIT_LAST  = NB_TICK_CNT'(15);
    localparam logic [NB_TICK_CNT-1:0] STOP_LAST = NB_TICK_CNT'(SB_TICK - 1);
    localparam logic [NB_BIT-1:0]      DATA_LAST = NB_BIT'(NB_DATA - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
`endif

    state_t                 state_q;
    logic [NB_TICK_CNT-1:0] tick_q;
    logic [NB_BIT-1:0]      bit_q;
    logic [NB_DATA-1:0]     sreg_q;
    logic                   tx_q;
    logic                   done_q;
`ifdef UART_TX_PARITY_EN
    logic                   par_q;
`endif

    logic [NB_DATA-1:0]     sreg_shift;

    // Shift register contents after dropping the bit just sent
    assign sreg_shift = sreg_q >> 1;

    // Frame sequencer; o_tx is loaded with the level of the state being entered
    always_ff @(posedge clk) begin
        done_q <= 1'b0;
        if (i_rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (i_tx_start) begin
                        sreg_q  <= i_data;
                        tick_q  <= '0;
                        tx_q    <= 1'b0;
                        state_q <= START;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^i_data;
`endif
                    end
                end
                START: begin
                    if (i_s_tick) begin
                        if (tick_q == BIT_LAST) begin
                            tick_q  <= '0;
                            bit_q   <= '0;
                            tx_q    <= sreg_q[0];
                            state_q <= DATA;
                        end else begin
                            tick_q <= tick_q + NB_TICK_CNT'(1);
                        end
                    end
                end
                DATA: begin
                    if (i_s_tick) begin
                        if (tick_q == BIT_LAST) begin
                            tick_q <= '0;
                            sreg_q <= sreg_shift;
                            if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                                tx_q    <= par_q;
                                state_q <= PARITY;
`else
                                tx_q    <= 1'b1;
                                state_q <= STOP;
`endif
                            end else begin
                                bit_q <= bit_q + NB_BIT'(1);
                                tx_q  <= sreg_shift[0];
                            end
                        end else begin
                            tick_q <= tick_q + NB_TICK_CNT'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (i_s_tick) begin
                        if (tick_q == BIT_LAST) begin
                            tick_q  <= '0;
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            tick_q <= tick_q + NB_TICK_CNT'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    tx_q <= 1'b1;
                    if (i_s_tick) begin
                        if (tick_q == STOP_LAST) begin
                            tick_q  <= '0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            tick_q <= tick_q + NB_TICK_CNT'(1);
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    tick_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_tx           = tx_q;
    assign o_tx_done_tick = done_q;
    assign o_busy         = (state_q != IDLE);

endmodule
